// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding and entry layout helpers for the trace capture buffer
package trace_pkg;
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3;
  localparam int FLAG_W = 3;
  function automatic int entry_w(input int pc_w, input int instr_w, input int data_w);
    return pc_w + instr_w + data_w + FLAG_W;
  endfunction
  function automatic int alu_off();
    return FLAG_W;
  endfunction
  function automatic int instr_off(input int data_w);
    return FLAG_W + data_w;
  endfunction
  function automatic int pc_off(input int instr_w, input int data_w);
    return FLAG_W + data_w + instr_w;
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W register array, synchronous write, asynchronous read, contents not reset
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W = 29,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/trace_capture.sv
// trace_capture: armed/triggered circular trace of the CPU debug bus, read out oldest-first over valid/ready
// ports: arm/force_trig/trig_en/trig_pc/post_count control capture; sample_en + pc/instr/alu/flags feed entries;
// rd_valid/rd_ready/rd_data/rd_last stream the frozen buffer; state and fill report progress
module trace_capture import trace_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int PC_W = 8,
  parameter int INSTR_W = 10,
  parameter int DATA_W = 8,
  parameter int ENTRY_W = entry_w(PC_W, INSTR_W, DATA_W),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               force_trig,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [AW-1:0]      post_count,
  input  logic               sample_en,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  alu_in,
  input  logic               zero_in,
  input  logic               carry_in,
  input  logic               neg_in,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_last,
  output logic [1:0]         state,
  output logic [AW:0]        fill
);
  logic [AW-1:0] wr_ptr, rd_ptr, post_left, wr_ptr_nxt;
  logic [AW:0] remaining, fill_nxt;
  logic force_pend, write, trig, done_now, xfer, do_arm;
  assign write = sample_en && (state == ARMED || state == POST);
  assign trig = state == ARMED && sample_en && ((trig_en && pc_in == trig_pc) || force_trig || force_pend);
  assign done_now = (trig && post_left == '0) || (write && state == POST && post_left == AW'(1));
  assign xfer = state == DONE && rd_valid && rd_ready;
  assign do_arm = arm && (state == IDLE || state == DONE);
  assign wr_ptr_nxt = wr_ptr + 1'b1;
  assign fill_nxt = fill == (AW+1)'(DEPTH) ? fill : fill + 1'b1;
  assign rd_last = rd_valid && remaining == (AW+1)'(1);
  trace_ram #(.DEPTH(DEPTH), .W(ENTRY_W)) u_ram (
    .clk(clk), .we(write), .waddr(wr_ptr),
    .wdata({pc_in, instr_in, alu_in, zero_in, carry_in, neg_in}),
    .raddr(rd_ptr), .rdata(rd_data)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      post_left <= '0;
      remaining <= '0;
      rd_valid <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr_nxt;
        fill <= fill_nxt;
      end
      // a force pulse between qualified cycles triggers on the next sample
      if (state == ARMED && force_trig && !sample_en) force_pend <= 1'b1;
      if (do_arm) begin
        state <= ARMED;
        fill <= '0;
        wr_ptr <= '0;
        post_left <= post_count;
        remaining <= '0;
        rd_valid <= 1'b0;
        force_pend <= 1'b0;
      end else if (done_now) begin
        state <= DONE;
        post_left <= '0;
        // with a full buffer fill_nxt wraps to 0 here, making the oldest entry the one after the newest
        rd_ptr <= wr_ptr_nxt - fill_nxt[AW-1:0];
        remaining <= fill_nxt;
        rd_valid <= 1'b1;
        force_pend <= 1'b0;
      end else if (trig) begin
        state <= POST;
        force_pend <= 1'b0;
      end else if (write && state == POST) begin
        post_left <= post_left - 1'b1;
      end else if (xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
        if (remaining == (AW+1)'(1)) begin
          rd_valid <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: randomized capture/readout scenarios checked against a history-queue reference model
module tb_trace_capture;
  import trace_pkg::*;
  localparam int DEPTH = 16, EW = 29, PCO = pc_off(10, 8);
  logic clk = 0, reset = 1, arm = 0, force_trig = 0, trig_en = 0, sample_en = 0, rd_ready = 0;
  logic zero_in = 0, carry_in = 0, neg_in = 0;
  logic [7:0] trig_pc = 0, pc_in = 0, alu_in = 0;
  logic [9:0] instr_in = 0;
  logic [3:0] post_count = 0;
  logic rd_valid, rd_last;
  logic [EW-1:0] rd_data;
  logic [1:0] state;
  logic [4:0] fill;
  int n_chk = 0, n_pass = 0;
  int m_state = 0, m_post = 0, m_rd = 0;
  bit m_pend = 0;
  logic [EW-1:0] q[$];
  always #5 clk = ~clk;
  trace_capture dut (
    .clk(clk), .reset(reset), .arm(arm), .force_trig(force_trig), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_count(post_count), .sample_en(sample_en), .pc_in(pc_in),
    .instr_in(instr_in), .alu_in(alu_in), .zero_in(zero_in), .carry_in(carry_in), .neg_in(neg_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .state(state), .fill(fill)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_arm();
    q.delete();
    m_post = int'(post_count);
    m_pend = 0;
    m_rd = 0;
    m_state = 1;
  endtask
  task automatic model_push();
    q.push_back({pc_in, instr_in, alu_in, zero_in, carry_in, neg_in});
    if (q.size() > DEPTH) void'(q.pop_front());
  endtask
  task automatic model_step();
    if (reset) return;
    case (m_state)
      0: if (arm) model_arm();
      1: if (sample_en) begin
        model_push();
        if ((trig_en && pc_in == trig_pc) || force_trig || m_pend) begin
          m_pend = 0;
          m_rd = 0;
          m_state = m_post == 0 ? 3 : 2;
        end
      end else if (force_trig) m_pend = 1;
      2: if (sample_en) begin
        model_push();
        m_post--;
        if (m_post == 0) begin
          m_rd = 0;
          m_state = 3;
        end
      end
      default: if (arm) model_arm();
        else if (m_rd < q.size() && rd_ready) begin
          m_rd++;
          if (m_rd == q.size()) m_state = 0;
        end
    endcase
  endtask
  task automatic check_outputs();
    bit v;
    v = m_state == 3 && m_rd < q.size();
    chk("state", state, m_state);
    chk("fill", fill, q.size());
    chk("rd_valid", rd_valid, v);
    if (v) begin
      chk("rd_data", rd_data, q[m_rd]);
      chk("rd_last", rd_last, m_rd == q.size() - 1);
    end else chk("rd_last_idle", rd_last, 0);
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask
  task automatic set_sample(input bit se, input int pc);
    sample_en = se;
    pc_in = 8'(pc);
    instr_in = 10'($urandom);
    alu_in = 8'($urandom);
    {zero_in, carry_in, neg_in} = 3'($urandom);
  endtask
  task automatic do_arm(input int tp, input int pcnt, input bit ten);
    trig_pc = 8'(tp);
    post_count = 4'(pcnt);
    trig_en = ten;
    arm = 1;
    cyc();
    arm = 0;
  endtask
  task automatic capture(input int max, input bit gaps, input bit rnd_force);
    int pc = 0;
    for (int i = 0; i < max && (m_state == 1 || m_state == 2); i++) begin
      set_sample(gaps ? 1'($urandom_range(0, 1)) : 1'b1, pc);
      force_trig = rnd_force && $urandom_range(0, 15) == 0;
      arm = $urandom_range(0, 7) == 0;
      pc++;
      cyc();
    end
    sample_en = 0;
    force_trig = 0;
    arm = 0;
    if (m_state != 3) chk("capture_timeout", state, 3);
  endtask
  task automatic readout(input int mode);
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 300 && m_state == 3; i++) begin
      rd_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[i % 6] : 1'($urandom_range(0, 1));
      cyc();
    end
    rd_ready = 0;
    if (m_state != 0) chk("readout_timeout", state, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_fill", fill, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_last", rd_last, 0);
    reset = 0;
    cyc();
    // basic: trigger at PC 5, three post samples, arm while ARMED ignored
    do_arm(5, 3, 1);
    for (int pc = 0; pc < 40 && (m_state == 1 || m_state == 2); pc++) begin
      set_sample(1, pc);
      arm = pc == 2;
      cyc();
    end
    arm = 0;
    sample_en = 0;
    chk("basic_done", state, 3);
    chk("basic_fill", fill, 9);
    chk("basic_first_pc", rd_data[PCO +: 8], 0);
    readout(0);
    // gaps: PC match only on an unqualified cycle, then a pending force
    do_arm(7, 0, 1);
    for (int pc = 0; pc < 12; pc++) begin
      set_sample(pc % 2 == 0, pc);
      cyc();
    end
    chk("gap_no_trig", state, 1);
    force_trig = 1;
    set_sample(0, 99);
    cyc();
    force_trig = 0;
    chk("force_pending", state, 1);
    set_sample(1, 12);
    cyc();
    sample_en = 0;
    chk("force_done", state, 3);
    chk("force_fill", fill, 7);
    readout(1);
    // wrap: trigger at 30, two post samples, then re-arm after three reads
    do_arm(30, 2, 1);
    capture(60, 0, 0);
    chk("wrap_fill", fill, 16);
    chk("wrap_first_pc", rd_data[PCO +: 8], 17);
    rd_ready = 1;
    repeat (3) cyc();
    rd_ready = 0;
    do_arm(5, 3, 1);
    chk("rearm_state", state, 1);
    chk("rearm_fill", fill, 0);
    chk("rearm_valid", rd_valid, 0);
    // reset in POST with two samples left
    for (int pc = 0; pc < 7; pc++) begin
      set_sample(1, pc);
      cyc();
    end
    sample_en = 0;
    chk("pre_reset_state", state, 2);
    #2 reset = 1;
    #1;
    q.delete();
    m_state = 0;
    m_rd = 0;
    m_pend = 0;
    chk("midreset_state", state, 0);
    chk("midreset_fill", fill, 0);
    chk("midreset_valid", rd_valid, 0);
    cyc();
    reset = 0;
    cyc();
    do_arm(5, 3, 1);
    capture(40, 0, 0);
    chk("again_fill", fill, 9);
    readout(0);
    // randomized captures
    for (int r = 0; r < 12; r++) begin
      do_arm($urandom_range(0, 50), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      capture(200, 1, 1);
      readout(2);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
Debug trace buffer downstream of the CPU top level. Consumes the CPU debug bus (PC, instruction, ALU result, flags) once per qualified cycle into a circular buffer. Capture is armed by software or a switch, stopped by a PC-match or force trigger plus a programmable post-trigger count, then frozen. Entries are read out oldest-first over a valid/ready port, for example to a UART or display stepper.

Parameters:
DEPTH, 16, buffer entries; power of two, at least 4
PC_W, 8, PC width
INSTR_W, 10, instruction width
DATA_W, 8, ALU result width
ENTRY_W, PC_W+INSTR_W+DATA_W+3, packed entry width (29 by default)

Ports:
clk  in  1  system clock, same clock as the CPU
reset  in  1  asynchronous, active-high reset
arm  in  1  pulse; starts a capture from IDLE or DONE
force_trig  in  1  pulse; triggers immediately while ARMED
trig_en  in  1  enables PC-match trigger
trig_pc  in  PC_W  PC value to match
post_count  in  log2(DEPTH)  samples taken after the trigger sample; latched on arm
sample_en  in  1  qualifies the current CPU cycle (tie 1 if the CPU runs every clk)
pc_in  in  PC_W  from dbg_pc_output
instr_in  in  INSTR_W  from dbg_instruction
alu_in  in  DATA_W  from dbg_ALU_output
zero_in, carry_in, neg_in  in  1 each  CPU flags
rd_valid  out  1  readout entry available
rd_ready  in  1  consumer accepts the entry
rd_data  out  ENTRY_W  packed {pc, instr, alu, zero, carry, neg}
rd_last  out  1  asserted with the final (newest) entry
state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
fill  out  log2(DEPTH)+1  number of valid entries, saturates at DEPTH

Behaviour:
- Reset (asynchronous): state=IDLE; wr_ptr, rd_ptr, fill and post_left=0; rd_valid=0; rd_last=0. Buffer contents are don't-care.
- IDLE: sample_en is ignored. On arm: fill=0, wr_ptr=0, post_left=min(post_count, DEPTH-1), then go to ARMED.
- ARMED:
  - Each sample_en cycle writes the entry to mem[wr_ptr], increments wr_ptr (mod DEPTH) and fill (saturating).
  - Trigger = sample_en && ((trig_en && pc_in==trig_pc) || force_trig). force_trig without sample_en is held pending until the next sample_en.
  - On trigger, the trigger sample is written in the same cycle. Go to DONE if post_left==0, else go to POST.
- POST: each sample_en writes as in ARMED and decrements post_left. The write that takes post_left to 0 moves to DONE in the same cycle. Triggers are ignored.
- Entry to DONE: rd_ptr=(wr_ptr_next - fill_next) mod DEPTH. rd_valid=1 if fill>0.
- DONE:
  - Writes are frozen.
  - rd_data=mem[rd_ptr], combinational from the registered rd_ptr.
  - A transfer occurs on rd_valid && rd_ready; it increments rd_ptr and decrements the remaining count.
  - rd_last=1 when remaining==1.
  - After the transfer with rd_last, rd_valid drops next cycle and the state goes to IDLE.
  - rd_data and rd_valid must hold stable while rd_valid && !rd_ready.
- arm is ignored in ARMED and POST. arm in DONE abandons the readout and re-arms (rd_valid=0 next cycle).
- Wrap-around: once fill==DEPTH, each write overwrites the oldest entry. Readout always returns exactly fill entries, oldest first, ending with the newest.
- The post_count clamp to DEPTH-1 guarantees the trigger sample survives in the buffer.
- A reset mid-capture or mid-readout returns to IDLE immediately, and rd_valid falls asynchronously.

Decomposition:
- Shared package trace_pkg: state encoding constants (IDLE/ARMED/POST/DONE), entry field offsets, ENTRY_W function.
- One sub-module, trace_ram: DEPTH x ENTRY_W register array with synchronous write and asynchronous read, no reset on contents.
- Control FSM, pointers and counters live in trace_capture.

Test Plan:
- Basic: DEPTH=16, trig_pc=5, post_count=3, arm, then PC 0,1,2,... with sample_en=1 → DONE after PC 8 written; fill=9; readout PCs 0..8 with matching instr/alu/flags; rd_last only on PC 8.
- Wrap: trig_pc=30, post_count=2, PCs 0..40 → fill=16; readout PCs 17..32 in order; rd_last on 32.
- Gaps and force: sample_en toggling 1/0, with trig_pc matched only on a sample_en=0 cycle → no trigger. Then force_trig pulse while sample_en=0, followed by sample_en=1 at PC 12 with post_count=0 → DONE, newest entry PC 12.
- Backpressure: in DONE, drive rd_ready as pattern 1,0,0,1,0,1... → every entry delivered exactly once, in order; rd_data stable while stalled.
- Arm rules: arm during ARMED → no effect (fill keeps counting). arm during DONE after 3 reads → state=ARMED, fill=0, rd_valid=0.
- Reset mid-POST (post_left=2) → state=0, fill=0, rd_valid=0. A subsequent arm and capture behaves as in the Basic scenario.
